// File: rtl/seq_checker.sv
`timescale 1ns/1ps
// Receive-side checker for an incrementing counter stream: locks after RESYNC_LEN
// consecutive in-order samples, then flags and counts breaks in the sequence.
module seq_checker #(
  parameter int WIDTH         = 32,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int RESYNC_LEN    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     locked,
  output logic                     mismatch,
  output logic [WIDTH-1:0]         expected,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int RUN_W = $clog2(RESYNC_LEN + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [RUN_W-1:0]         run_r, run_s;
  logic [WIDTH-1:0]         expected_s;
  logic [ERR_CNT_WIDTH-1:0] err_count_s;
  logic                     mismatch_s;
  logic                     match_s;
  logic [WIDTH-1:0]         next_pred_s;
  state_t                   restart_state_s;

  assign match_s         = (in_data == expected);
  assign next_pred_s     = in_data + WIDTH'(1);
  assign restart_state_s = (RESYNC_LEN == 32'sd1) ? ST_LOCKED : ST_RESYNC;

  // Next-state, run length, prediction and error-count computation
  always_comb begin
    state_s     = state_r;
    run_s       = run_r;
    expected_s  = expected;
    err_count_s = err_count;
    mismatch_s  = 1'b0;
    if (clear) begin
      state_s     = ST_HUNT;
      run_s       = {RUN_W{1'b0}};
      err_count_s = {ERR_CNT_WIDTH{1'b0}};
    end else if (in_valid) begin
      expected_s = next_pred_s;
      case (state_r)
        ST_HUNT: begin
          run_s   = RUN_W'(1);
          state_s = restart_state_s;
        end
        ST_RESYNC: begin
          if (match_s) begin
            run_s = run_r + RUN_W'(1);
            if ((run_r + RUN_W'(1)) == RUN_W'(RESYNC_LEN)) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_RESYNC;
            end
          end else begin
            run_s   = RUN_W'(1);
            state_s = ST_RESYNC;
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            state_s = ST_LOCKED;
          end else begin
            mismatch_s = 1'b1;
            run_s      = RUN_W'(1);
            state_s    = restart_state_s;
            // Saturate at all-ones rather than wrapping
            if (err_count == {ERR_CNT_WIDTH{1'b1}}) begin
              err_count_s = err_count;
            end else begin
              err_count_s = err_count + ERR_CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_s = ST_HUNT;
          run_s   = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_HUNT;
      run_r     <= {RUN_W{1'b0}};
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      expected  <= {WIDTH{1'b0}};
      err_count <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      run_r     <= run_s;
      locked    <= (state_s == ST_LOCKED);
      mismatch  <= mismatch_s;
      expected  <= expected_s;
      err_count <= err_count_s;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
`timescale 1ns/1ps
// Scoreboard bench for seq_checker: two instances (RESYNC_LEN=4/16-bit count and
// RESYNC_LEN=1/2-bit count) share one stimulus stream and a sample-history model.
module tb_seq_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;

  logic        locked0, mis0, locked1, mis1;
  logic [31:0] exp0, exp1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 CLK = ~CLK;

  seq_checker #(.WIDTH(32), .ERR_CNT_WIDTH(16), .RESYNC_LEN(4)) dut0 (
    .CLK(CLK), .RST(RST), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked0), .mismatch(mis0), .expected(exp0), .err_count(cnt0)
  );

  seq_checker #(.WIDTH(32), .ERR_CNT_WIDTH(2), .RESYNC_LEN(1)) dut1 (
    .CLK(CLK), .RST(RST), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked1), .mismatch(mis1), .expected(exp1), .err_count(cnt1)
  );

  typedef struct packed {
    logic        l0;
    logic        m0;
    logic [31:0] e0;
    logic [15:0] c0;
    logic        l1;
    logic        m1;
    logic [31:0] e1;
    logic [1:0]  c1;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: length of the current in-order streak, lock flag, prediction
  bit          m_locked[2];
  bit          m_mis[2];
  logic [31:0] m_exp[2];
  int          m_run[2];
  int          m_err[2];

  function automatic int rlen(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int errmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 1'b0;
      m_mis[i]    = 1'b0;
      m_exp[i]    = 32'd0;
      m_run[i]    = 0;
      m_err[i]    = 0;
    end
  endtask

  task automatic model_step(input int i, input bit v, input logic [31:0] d, input bit c);
    bit in_order;
    m_mis[i] = 1'b0;
    if (c) begin
      m_locked[i] = 1'b0;
      m_run[i]    = 0;
      m_err[i]    = 0;
    end else if (v) begin
      in_order = (d == m_exp[i]);
      if (m_locked[i]) begin
        if (!in_order) begin
          m_mis[i]    = 1'b1;
          m_err[i]    = (m_err[i] < errmax(i)) ? m_err[i] + 1 : m_err[i];
          m_run[i]    = 1;
          m_locked[i] = (rlen(i) == 1);
        end
      end else begin
        m_run[i]    = (m_run[i] > 0 && in_order) ? m_run[i] + 1 : 1;
        m_locked[i] = (m_run[i] >= rlen(i));
      end
      m_exp[i] = d + 32'd1;
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit c);
    exp_t e;
    @(negedge CLK);
    in_valid = v;
    in_data  = d;
    clear    = c;
    for (int i = 0; i < 2; i++) model_step(i, v, d, c);
    e.l0 = m_locked[0]; e.m0 = m_mis[0]; e.e0 = m_exp[0]; e.c0 = 16'(m_err[0]);
    e.l1 = m_locked[1]; e.m1 = m_mis[1]; e.e1 = m_exp[1]; e.c1 = 2'(m_err[1]);
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".locked0"}, 32'(locked0), 32'd0);
    chk({tag, ".mis0"},    32'(mis0),    32'd0);
    chk({tag, ".exp0"},    exp0,         32'd0);
    chk({tag, ".cnt0"},    32'(cnt0),    32'd0);
    chk({tag, ".locked1"}, 32'(locked1), 32'd0);
    chk({tag, ".mis1"},    32'(mis1),    32'd0);
    chk({tag, ".exp1"},    exp1,         32'd0);
    chk({tag, ".cnt1"},    32'(cnt1),    32'd0);
  endtask

  // Monitor: outputs settle after each rising edge; compare against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("locked0",   32'(locked0), 32'(e.l0));
        chk("mismatch0", 32'(mis0),    32'(e.m0));
        chk("expected0", exp0,         e.e0);
        chk("err0",      32'(cnt0),    32'(e.c0));
        chk("locked1",   32'(locked1), 32'(e.l1));
        chk("mismatch1", 32'(mis1),    32'(e.m1));
        chk("expected1", exp1,         e.e1);
        chk("err1",      32'(cnt1),    32'(e.c1));
      end
    end
  end

  initial begin
    bit          v, c;
    int          r;
    logic [31:0] d;
    RST = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    model_reset();
    #3;
    chk_reset_vals("por");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Lock from reset, then a break at 20 and re-lock
    for (int k = 0; k < 12; k++) cyc(1'b1, 32'(k), 1'b0);
    cyc(1'b1, 32'd20, 1'b0);
    for (int k = 21; k < 24; k++) cyc(1'b1, 32'(k), 1'b0);
    cyc(1'b0, 32'd0, 1'b0);

    // Break near the top, re-lock, then wrap through all-ones
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'hFFFF_FFFA + 32'(k), 1'b0);

    // Five out-of-order samples saturate the 2-bit counter
    for (int k = 1; k <= 5; k++) cyc(1'b1, 32'(k * 100), 1'b0);
    for (int k = 501; k < 505; k++) cyc(1'b1, 32'(k), 1'b0);

    // Clear together with a sample: the sample is ignored
    cyc(1'b1, 32'd99, 1'b1);
    cyc(1'b0, 32'd0, 1'b0);

    // Randomized stream with gaps, occasional breaks and clears
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      c = (r < 3);
      d = (r < 88) ? m_exp[0] : $urandom;
      cyc(v, d, c);
    end

    // Asynchronous reset while locked, between clock edges
    for (int k = 0; k < 6; k++) cyc(1'b1, 32'd700 + 32'(k), 1'b0);
    @(posedge CLK);
    #3;
    in_valid = 1'b0;
    clear    = 1'b0;
    RST      = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) cyc(1'b1, 32'd50 + 32'(k), 1'b0);
    cyc(1'b0, 32'd0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
